// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm controller slice.
//   state_t          : 2-bit controller state encoding
//                      (DISARMED=0, ARMED=1, ENTRY=2, ALARM=3)
//   DEF_*            : default parameter values for the controller
//   timer_width()    : width of the shared entry/siren down counter
// Optional feature macro used by the slice: ALARM_PANIC_EN (adds a panic input).
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ENTRY    = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  localparam int DEF_DELAY_CYCLES = 4;
  localparam int DEF_SIREN_CYCLES = 6;
  localparam int DEF_CNT_W        = 8;

  // One extra bit over the longest load value keeps the counter comfortably
  // wide enough for either phase.
  function automatic int timer_width(input int delay_cycles, input int siren_cycles);
    int longest;
    longest = (delay_cycles > siren_cycles) ? delay_cycles : siren_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
// Loadable unsigned down counter shared by the entry-delay and siren phases.
// The count stops at zero (never wraps); load has priority over decrement.
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high; clears the count to 0
//   load     in   1  load load_val on the next edge
//   load_val in   W  value to load
//   en       in   1  decrement on the next edge when the count is non-zero
//   zero     out  1  count is 0
// -----------------------------------------------------------------------------
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
// Sequential alarm controller downstream of the combinational sensor logic.
// Handles arm/disarm, an entry delay, a time-limited siren and a saturating
// count of alarm events. All outputs are Moore, decoded from the registered
// state, so no input reaches an output combinationally.
//
// Optional feature: `define ALARM_PANIC_EN adds a panic input that forces
// ALARM from DISARMED/ARMED/ENTRY (disarm still wins; ignored in ALARM).
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   arm        in   1      request arming (level)
//   disarm     in   1      request disarming (level), highest priority
//   trig       in   1      sensor alarm-logic output, synchronous to clk
//   panic      in   1      (ALARM_PANIC_EN only) immediate alarm request
//   armed      out  1      state is not DISARMED
//   pending    out  1      entry delay running
//   siren      out  1      siren on
//   alarm_cnt  out  CNT_W  number of ALARM entries, saturating
//   state      out  2      debug view of the FSM state register
//
// Handshake note: there is no valid/ready handshake here; every input is a
// level sampled on each rising edge and every output is valid every cycle.
// -----------------------------------------------------------------------------
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int SIREN_CYCLES = DEF_SIREN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             disarm,
  input  logic             trig,
`ifdef ALARM_PANIC_EN
  input  logic             panic,
`endif
  output logic             armed,
  output logic             pending,
  output logic             siren,
  output logic [CNT_W-1:0] alarm_cnt,
  output logic [1:0]       state
);

  localparam int TIMER_W = timer_width(DELAY_CYCLES, SIREN_CYCLES);

  // The timer is loaded with length-1 because the loading edge itself is
  // the first cycle of the phase; the phase ends on the edge seeing zero.
  localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_zero;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_q;

  alarm_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, timer control and counter increment
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    cnt_inc  = 1'b0;

    if (disarm) begin
      // Disarm wins over everything; clearing the timer here keeps it at 0
      // for the whole DISARMED stay.
      state_d  = ST_DISARMED;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
`ifdef ALARM_PANIC_EN
    else if (panic && (state_q != ST_ALARM)) begin
      state_d  = ST_ALARM;
      tmr_load = 1'b1;
      tmr_val  = SIREN_LOAD;
      cnt_inc  = 1'b1;
    end
`endif
    else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (trig) begin
            state_d  = ST_ENTRY;
            tmr_load = 1'b1;
            tmr_val  = DELAY_LOAD;
          end
        end

        ST_ENTRY: begin
          // trig is deliberately ignored so the delay is never restarted.
          if (tmr_zero) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LOAD;
            cnt_inc  = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end

        ST_ALARM: begin
          // Auto re-arm; a trig still held high re-enters ENTRY next edge.
          if (tmr_zero) begin
            state_d = ST_ARMED;
          end else begin
            tmr_en = 1'b1;
          end
        end

        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    armed   = (state_q != ST_DISARMED);
    pending = (state_q == ST_ENTRY);
    siren   = (state_q == ST_ALARM);
    state   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Saturating alarm event counter; only reset clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alarm_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
// Self-checking bench for alarm_controller (DELAY=4, SIREN=6, CNT_W=2).
// Directed scenarios followed by random arm/disarm/trig(/panic) traffic.
// Every clock the driver pushes the reference model's expected outputs into
// exp_q; the monitor pops and compares on the falling edge.
// Define ALARM_PANIC_EN for both RTL and bench to exercise the panic input.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

  localparam int DELAY = 4;
  localparam int SIREN = 6;
  localparam int CNT_W = 2;
  localparam int W     = 2 + 3 + CNT_W;   // {state, armed, pending, siren, cnt}
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic arm;
  logic disarm;
  logic trig;
`ifdef ALARM_PANIC_EN
  logic panic;
`endif
  logic             armed;
  logic             pending;
  logic             siren;
  logic [CNT_W-1:0] alarm_cnt;
  logic [1:0]       state;

  always #5 clk = ~clk;

  alarm_controller #(
    .DELAY_CYCLES (DELAY),
    .SIREN_CYCLES (SIREN),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .disarm    (disarm),
    .trig      (trig),
`ifdef ALARM_PANIC_EN
    .panic     (panic),
`endif
    .armed     (armed),
    .pending   (pending),
    .siren     (siren),
    .alarm_cnt (alarm_cnt),
    .state     (state)
  );

  // ---------------------------------------------------------------------------
  // Reference model: mode plus remaining cycles in the current timed phase
  // ---------------------------------------------------------------------------
  typedef enum int {M_OFF, M_ON, M_WAIT, M_SIREN} mode_t;
  mode_t m_mode;
  int    m_left;
  int    m_cnt;

  function automatic void model_reset();
    m_mode = M_OFF;
    m_left = 0;
    m_cnt  = 0;
  endfunction

  function automatic void start_siren();
    m_mode = M_SIREN;
    m_left = SIREN;
    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endfunction

  function automatic void model_step(input bit a, input bit d, input bit t, input bit p);
    if (d) begin
      m_mode = M_OFF;
      m_left = 0;
    end
`ifdef ALARM_PANIC_EN
    else if (p && m_mode != M_SIREN) begin
      start_siren();
    end
`endif
    else begin
      case (m_mode)
        M_OFF:   if (a) m_mode = M_ON;
        M_ON:    if (t) begin m_mode = M_WAIT; m_left = DELAY; end
        M_WAIT:  begin
          m_left = m_left - 1;
          if (m_left == 0) start_siren();
        end
        M_SIREN: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_ON;
        end
        default: m_mode = M_OFF;
      endcase
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [1:0]       code;
    logic [CNT_W-1:0] c;
    case (m_mode)
      M_OFF:   code = 2'd0;
      M_ON:    code = 2'd1;
      M_WAIT:  code = 2'd2;
      default: code = 2'd3;
    endcase
    c = CNT_W'(m_cnt);
    return {code, (m_mode != M_OFF), (m_mode == M_WAIT), (m_mode == M_SIREN), c};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {state,armed,pending,siren,cnt}=%b, expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check($sformatf("cycle %0d", cyc), {state, armed, pending, siren, alarm_cnt},
            exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input bit a, input bit d, input bit t, input bit p);
    @(negedge clk);
    arm    = a;
    disarm = d;
    trig   = t;
`ifdef ALARM_PANIC_EN
    panic  = p;
`endif
    @(posedge clk);
    #1;
    model_step(a, d, t, p);
    exp_q.push_back(model_outputs());
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    reset  = 1'b1;
    arm    = 1'b0;
    disarm = 1'b0;
    trig   = 1'b0;
`ifdef ALARM_PANIC_EN
    panic  = 1'b0;
`endif
    model_reset();
    #1;
    check(name, {state, armed, pending, siren, alarm_cnt}, model_outputs());
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    arm    = 1'b0;
    disarm = 1'b0;
    trig   = 1'b0;
`ifdef ALARM_PANIC_EN
    panic  = 1'b0;
`endif
    model_reset();
    #1;
    check("power-on reset", {state, armed, pending, siren, alarm_cnt}, model_outputs());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single alarm: 4 pending cycles, 6 siren cycles, back to armed, cnt=1.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);

    // Disarm during the second entry cycle: siren never fires.
    do_reset("reset before abort");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // arm+disarm together from ARMED, then trig held while disarmed.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // trig held through four alarms: counter 1,2,3,3; stop mid-ALARM.
    do_reset("reset before saturation");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("async reset mid-ALARM");

`ifdef ALARM_PANIC_EN
    step(1'b0, 1'b0, 1'b0, 1'b1);          // panic from DISARMED
    idle(7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);          // disarm beats panic
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);          // panic during entry
    step(1'b0, 1'b0, 1'b0, 1'b1);          // panic ignored in ALARM
    idle(7);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit a, d, t, p;
      a = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 19) == 0);
      step(a, d, t, p);
      if ($urandom_range(0, 149) == 0) do_reset("random reset");
    end

    // Drain: the last expectation is consumed on the next falling edge.
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
